// File: rtl/sr_pq_ctrl.sv
// Front-end controller for the sr_pq shift-register priority queue array.
// Maps valid/ready enqueue/dequeue ports onto push/pop strobes and drains the array on flush.
package pq_pkg;
  parameter int KEY_W = 8;
  parameter int VAL_W = 8;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] val;
  } kv_t;

  // Empty stages hold the largest key so they always sort behind real entries.
  localparam kv_t KV_EMPTY = '{key: '1, val: '0};
endpackage

module sr_pq_ctrl
  import pq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq_valid,
  input  kv_t              enq_kv,
  output logic             enq_ready,
  output logic             deq_valid,
  output kv_t              deq_kv,
  input  logic             deq_ready,
  input  logic             flush,
  output logic             flush_done,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] peak,
  output logic             full,
  output logic             empty,
  output logic             pq_push,
  output logic             pq_pop,
  output kv_t              pq_kvi,
  input  kv_t              pq_top
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] peak_reg;
  logic [CNT_W-1:0] count_next;
  logic             is_run;

  always_comb begin
    is_run     = (state_reg == RUN);
    full       = (count_reg == DEPTH_C);
    empty      = (count_reg == '0);
    deq_valid  = is_run & ~empty;
    deq_kv     = pq_top;
    // When full, a same-cycle pop frees the slot, hence the deq_ready term.
    enq_ready  = is_run & (~full | deq_ready);
    pq_push    = enq_valid & enq_ready;
    pq_pop     = is_run ? (deq_valid & deq_ready) : ~empty;
    pq_kvi     = enq_kv;
    flush_done = ~is_run & empty;
    count      = count_reg;
    peak       = peak_reg;

    count_next = count_reg;
    if (pq_push && !pq_pop) begin
      count_next = count_reg + CNT_W'(1);
    end else if (pq_pop && !pq_push) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= RUN;
      count_reg <= '0;
      peak_reg  <= '0;
    end else begin
      count_reg <= count_next;
      case (state_reg)
        RUN: begin
          if (flush) begin
            state_reg <= FLUSH;
          end
          if (count_next > peak_reg) begin
            peak_reg <= count_next;
          end
        end
        FLUSH: begin
          // Flush input is ignored here; completion returns to RUN and clears peak.
          if (empty) begin
            state_reg <= RUN;
            peak_reg  <= '0;
          end
        end
        default: state_reg <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_pq_ctrl.sv
// Bench for sr_pq_ctrl: behavioural array stub, sorted-queue reference model, directed vectors.
module tb_sr_pq_ctrl;
  import pq_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic             enq_valid;
  kv_t              enq_kv;
  logic             enq_ready;
  logic             deq_valid;
  kv_t              deq_kv;
  logic             deq_ready;
  logic             flush;
  logic             flush_done;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] peak;
  logic             full;
  logic             empty;
  logic             pq_push;
  logic             pq_pop;
  kv_t              pq_kvi;
  kv_t              pq_top = KV_EMPTY;

  int tests = 0;
  int fails = 0;

  sr_pq_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_kv(enq_kv), .enq_ready(enq_ready),
    .deq_valid(deq_valid), .deq_kv(deq_kv), .deq_ready(deq_ready),
    .flush(flush), .flush_done(flush_done),
    .count(count), .peak(peak), .full(full), .empty(empty),
    .pq_push(pq_push), .pq_pop(pq_pop), .pq_kvi(pq_kvi), .pq_top(pq_top)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Array stub: a sorted list whose head is stage 1; push+pop removes the head then inserts.
  kv_t arr[$];
  always @(posedge clk or negedge rst) begin : array_stub
    int pos;
    if (!rst) begin
      arr.delete();
      pq_top <= KV_EMPTY;
    end else begin
      if (pq_pop && arr.size() > 0) void'(arr.pop_front());
      if (pq_push) begin
        pos = arr.size();
        for (int i = 0; i < arr.size(); i++) begin
          if (pq_kvi.key < arr[i].key) begin
            pos = i;
            break;
          end
        end
        arr.insert(pos, pq_kvi);
      end
      pq_top <= (arr.size() > 0) ? arr[0] : KV_EMPTY;
    end
  end

  // Reference model: queue contents, flushing flag and peak, checked mid-cycle.
  kv_t mq[$];
  bit  m_flush = 1'b0;
  int  m_peak  = 0;

  always @(negedge clk) begin : compare
    int  cnt;
    int  pos;
    bit  e_dv, e_er, e_push, e_pop, e_fd;
    if (!rst) begin
      mq.delete();
      m_flush = 1'b0;
      m_peak  = 0;
    end
    cnt    = mq.size();
    e_dv   = !m_flush && cnt > 0;
    e_er   = !m_flush && (cnt < DEPTH || deq_ready);
    e_push = e_er && enq_valid;
    e_pop  = m_flush ? (cnt > 0) : (e_dv && deq_ready);
    e_fd   = m_flush && cnt == 0;

    chk("deq_valid", int'(deq_valid), int'(e_dv));
    chk("enq_ready", int'(enq_ready), int'(e_er));
    chk("pq_push", int'(pq_push), int'(e_push));
    chk("pq_pop", int'(pq_pop), int'(e_pop));
    chk("flush_done", int'(flush_done), int'(e_fd));
    chk("count", int'(count), cnt);
    chk("peak", int'(peak), m_peak);
    chk("full", int'(full), int'(cnt == DEPTH));
    chk("empty", int'(empty), int'(cnt == 0));
    chk("pq_kvi", int'(pq_kvi), int'(enq_kv));
    if (e_dv) chk("deq_kv", int'(deq_kv), int'(mq[0]));

    if (rst) begin
      if (m_flush) begin
        if (cnt == 0) begin
          m_flush = 1'b0;
          m_peak  = 0;
        end else begin
          void'(mq.pop_front());
        end
      end else begin
        if (e_pop) void'(mq.pop_front());
        if (e_push) begin
          pos = mq.size();
          for (int i = 0; i < mq.size(); i++) begin
            if (enq_kv.key < mq[i].key) begin
              pos = i;
              break;
            end
          end
          mq.insert(pos, enq_kv);
        end
        if (flush) m_flush = 1'b1;
        if (mq.size() > m_peak) m_peak = mq.size();
      end
    end
  end

  task automatic drive(input bit ev, input logic [7:0] k, input bit dr, input bit fl);
    enq_valid = ev;
    enq_kv    = '{key: k, val: k ^ 8'hA5};
    deq_ready = dr;
    flush     = fl;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int keys3[3];
    int drain3[3];
    int n;
    int pops;
    bit done;
    keys3  = '{5, 3, 9};
    drain3 = '{3, 5, 9};

    rst = 1'b0;
    drive(0, 0, 0, 0);
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_flush_done", int'(flush_done), 0);
    chk("rst_push", int'(pq_push), 0);
    chk("rst_pop", int'(pq_pop), 0);
    tick;
    tick;
    rst = 1'b1;

    // Push 5,3,9 without dequeuing.
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'(keys3[i]), 0, 0);
      #1 chk("push_no_pop", int'(pq_pop), 0);
      tick;
      chk("push_count", int'(count), i + 1);
    end
    drive(0, 0, 0, 0);
    #1;
    chk("min_after_push", int'(deq_kv.key), 3);
    chk("peak_after_push", int'(peak), 3);

    // Drain in sorted order.
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0);
      #1;
      chk("drain_key", int'(deq_kv.key), drain3[i]);
      chk("drain_pop", int'(pq_pop), 1);
      tick;
      chk("drain_count", int'(count), 2 - i);
    end
    drive(0, 0, 0, 0);
    #1;
    chk("drained_valid", int'(deq_valid), 0);
    chk("drained_empty", int'(empty), 1);

    // Fill to DEPTH, then push+pop on full.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 8'(10 + i), 0, 0);
      tick;
    end
    chk("fill_full", int'(full), 1);
    chk("fill_peak", int'(peak), DEPTH);
    drive(1, 0, 0, 0);
    #1 chk("full_no_ready", int'(enq_ready), 0);
    drive(1, 0, 1, 0);
    #1;
    chk("full_push", int'(pq_push), 1);
    chk("full_pop", int'(pq_pop), 1);
    tick;
    drive(0, 0, 0, 0);
    chk("full_count_kept", int'(count), DEPTH);
    chk("full_new_min", int'(deq_kv.key), 0);

    n = 0;
    drive(0, 0, 1, 0);
    while (count != 0 && n < 20) begin
      tick;
      n++;
    end
    drive(0, 0, 0, 0);
    chk("drain_all_cycles", n, DEPTH);

    // Empty queue with both sides active: push only, no bypass.
    drive(1, 7, 1, 0);
    #1;
    chk("empty_both_pop", int'(pq_pop), 0);
    chk("empty_both_push", int'(pq_push), 1);
    chk("empty_both_valid", int'(deq_valid), 0);
    tick;
    drive(0, 0, 0, 0);
    chk("empty_both_count", int'(count), 1);
    chk("empty_both_valid_next", int'(deq_valid), 1);

    // Flush four entries while the producer keeps offering data.
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'(20 + i), 0, 0);
      tick;
    end
    drive(0, 0, 0, 0);
    chk("pre_flush_count", int'(count), 4);
    drive(0, 0, 0, 1);
    tick;
    drive(1, 99, 1, 1);
    n    = 0;
    pops = 0;
    done = 1'b0;
    while (!done && n < 12) begin
      n++;
      #1;
      chk("flush_enq_ready", int'(enq_ready), 0);
      if (pq_pop) pops++;
      if (flush_done) done = 1'b1;
      tick;
    end
    drive(0, 0, 0, 0);
    chk("flush_done_seen", int'(done), 1);
    chk("flush_cycles", n, 5);
    chk("flush_pops", pops, 4);
    chk("post_flush_count", int'(count), 0);
    chk("post_flush_peak", int'(peak), 0);

    // Asynchronous reset in the middle of a flush.
    drive(1, 30, 0, 0);
    tick;
    drive(1, 31, 0, 0);
    tick;
    drive(0, 0, 0, 1);
    tick;
    drive(0, 0, 0, 0);
    chk("mid_flush_count", int'(count), 2);
    chk("mid_flush_pop", int'(pq_pop), 1);
    rst = 1'b0;
    #1;
    chk("async_count", int'(count), 0);
    chk("async_flush_done", int'(flush_done), 0);
    chk("async_pop", int'(pq_pop), 0);
    chk("async_run_state", int'(enq_ready), 1);
    tick;
    rst = 1'b1;
    drive(1, 42, 0, 0);
    tick;
    drive(0, 0, 0, 0);
    chk("post_rst_count", int'(count), 1);
    chk("post_rst_key", int'(deq_kv.key), 42);
    tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
